// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a two-state data-memory access FSM.
// Holds the M register (execute-stage fields), performs one data-memory
// request/acknowledge handshake per load or store, back-pressures the
// upstream while waiting, and produces the W register for writeback.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that is not
// acknowledged within TIMEOUT_CYCLES stalled cycles; dm_timeout is tied to 0
// otherwise.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_E,
    input  logic              Branch_E,
    input  logic              MemRead_E,
    input  logic              MemWrite_E,
    input  logic              RegWrite_E,
    input  logic              MemtoReg_E,
    input  logic              zero_E,
    input  logic [DATA_W-1:0] aluResult_E,
    input  logic [DATA_W-1:0] writeData_E,
    input  logic [DATA_W-1:0] PCBranch_E,
    input  logic [4:0]        rd_E,
    output logic              stall_M,
    output logic              PCSrc_M,
    output logic [DATA_W-1:0] PCBranch_M,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              valid_W,
    output logic              RegWrite_W,
    output logic              MemtoReg_W,
    output logic [4:0]        rd_W,
    output logic [DATA_W-1:0] readData_W,
    output logic [DATA_W-1:0] aluResult_W,
    output logic              dm_timeout
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state;
    logic              valid_M, Branch_M, MemRead_M, MemWrite_M;
    logic              RegWrite_M, MemtoReg_M, zero_M;
    logic [DATA_W-1:0] aluResult_M, writeData_M;
    logic [4:0]        rd_M;

    logic in_access;
    logic mem_op_E;
    logic mem_op_M;
    logic to_hit;

    assign in_access = (state == ACCESS);
    // A store takes priority when both read and write flags are set.
    assign mem_op_E  = valid_E & (MemRead_E | MemWrite_E);
    assign mem_op_M  = valid_M & (MemRead_M | MemWrite_M);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] to_cnt;

    // An unanswered access is forced to complete once the limit is reached;
    // a real ack arriving in that same cycle still wins.
    assign to_hit = in_access & ~dm_ack & (to_cnt == TO_LIMIT);

    // Count stalled ACCESS cycles; cleared whenever the stage advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            to_cnt <= '0;
        else if (!stall_M)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 8'd1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dm_timeout <= 1'b0;
        else if (to_hit)
            dm_timeout <= 1'b1;
    end
`else
    assign to_hit     = 1'b0;
    assign dm_timeout = 1'b0;
`endif

    // Stall only while waiting; the ack cycle itself lets the next op in.
    assign stall_M = in_access & ~dm_ack & ~to_hit;

    assign dm_req   = in_access & mem_op_M;
    assign dm_we    = in_access & MemWrite_M;
    assign dm_addr  = aluResult_M;
    assign dm_wdata = writeData_M;

    assign PCSrc_M  = valid_M & Branch_M & zero_M;

    // Access FSM: enter ACCESS whenever a memory op is captured into M.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else if (!stall_M)
            state <= mem_op_E ? ACCESS : IDLE;
    end

    // M register: captures execute-stage fields whenever not stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_M     <= 1'b0;
            Branch_M    <= 1'b0;
            MemRead_M   <= 1'b0;
            MemWrite_M  <= 1'b0;
            RegWrite_M  <= 1'b0;
            MemtoReg_M  <= 1'b0;
            zero_M      <= 1'b0;
            aluResult_M <= '0;
            writeData_M <= '0;
            PCBranch_M  <= '0;
            rd_M        <= '0;
        end else if (!stall_M) begin
            valid_M     <= valid_E;
            Branch_M    <= Branch_E;
            MemRead_M   <= MemRead_E;
            MemWrite_M  <= MemWrite_E;
            RegWrite_M  <= RegWrite_E;
            MemtoReg_M  <= MemtoReg_E;
            zero_M      <= zero_E;
            aluResult_M <= aluResult_E;
            writeData_M <= writeData_E;
            PCBranch_M  <= PCBranch_E;
            rd_M        <= rd_E;
        end
    end

    // W register: bubble while stalled, otherwise retire the M contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_W     <= 1'b0;
            RegWrite_W  <= 1'b0;
            MemtoReg_W  <= 1'b0;
            rd_W        <= '0;
            readData_W  <= '0;
            aluResult_W <= '0;
        end else if (stall_M) begin
            valid_W     <= 1'b0;
        end else begin
            valid_W     <= valid_M;
            RegWrite_W  <= RegWrite_M & ~to_hit;
            MemtoReg_W  <= MemtoReg_M;
            rd_W        <= rd_M;
            aluResult_W <= aluResult_M;
            readData_W  <= (in_access & ~MemWrite_M & ~to_hit) ? dm_rdata : '0;
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of ACCESS cycles without dm_ack before abort (range 2..255).
REQ-002 Port clk, in, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, in, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 Ports valid_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E, zero_E, in, 1 each: execute-stage qualifiers, flags and ALU zero.
REQ-005 Ports aluResult_E, writeData_E, PCBranch_E, in, 64 each: execute-stage ALU result, store data and branch target.
REQ-006 Port rd_E, in, 5: destination register.
REQ-007 Port stall_M, out, 1: back-pressure to upstream; the E inputs are not consumed while high.
REQ-008 Ports PCSrc_M, out, 1 and PCBranch_M, out, 64: branch-taken select and target to fetch.
REQ-009 Ports dm_req, dm_we, out, 1; dm_addr, dm_wdata, out, 64; dm_ack, in, 1; dm_rdata, in, 64: data-memory request/acknowledge port.
REQ-010 Ports valid_W, RegWrite_W, MemtoReg_W, out, 1; rd_W, out, 5; readData_W, aluResult_W, out, 64: writeback register outputs.
REQ-011 Port dm_timeout, out, 1: sticky memory-timeout flag.

Function
REQ-012 The M register (all E fields) SHALL load on each rising edge where stall_M=0, and hold otherwise.
REQ-013 The FSM SHALL have states IDLE and ACCESS.
REQ-014 A memory op SHALL be defined as valid & (MemRead | MemWrite); when both flags are set, MemWrite SHALL win.
REQ-015 When the M register loads a memory op, the next state SHALL be ACCESS; otherwise it SHALL be IDLE.
REQ-016 In ACCESS, dm_req=1, dm_we=MemWrite_M, dm_addr=aluResult_M and dm_wdata=writeData_M SHALL be driven and held stable until dm_ack.
REQ-017 In IDLE, dm_req=0.
REQ-018 stall_M SHALL equal (state==ACCESS) & ~dm_ack; the ack cycle is not stalled, which allows back-to-back memory ops with no idle cycle.
REQ-019 A memory op SHALL complete on the edge where dm_ack=1: the W register loads the M fields, and readData_W loads dm_rdata for reads and 0 for writes.
REQ-020 A non-memory valid op SHALL reach the W register one edge after entering M (latency 1); an invalid slot SHALL load valid_W=0.
REQ-021 dm_ack SHALL be ignored in IDLE.
REQ-022 PCSrc_M SHALL equal valid_M & Branch_M & zero_M, combinationally from the M register; PCBranch_M SHALL equal PCBranch_M-register.
REQ-023 While stall_M=1, the W register SHALL load valid_W=0 (bubble), so valid_W pulses exactly once per completed op.
REQ-024 All arithmetic is pass-through: no width change, no sign extension.

Reset
REQ-025 Reset assertion SHALL asynchronously force state=IDLE, all M and W register fields to 0, and dm_timeout=0.
REQ-026 As a result, dm_req, stall_M, PCSrc_M and valid_W SHALL all be 0 during reset.
REQ-027 Reset asserted mid-ACCESS SHALL drop dm_req immediately and abandon the op; no writeback SHALL occur.
REQ-028 Reset deassertion SHALL take effect at the next rising edge.

Configuration
REQ-029 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering ACCESS and increment each stalled ACCESS cycle.
REQ-030 When the counter reaches TIMEOUT_CYCLES, the op SHALL complete as if acked, except RegWrite_W=0 and readData_W=0; dm_timeout SHALL set and remain set until reset.
REQ-031 Without MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely for dm_ack, dm_timeout SHALL be tied to 0, and no counter SHALL exist.

Verification
REQ-032 Scenario: reset low for 3 cycles with random E inputs -> all outputs 0; after release, first op captured on the next edge.
REQ-033 Scenario: LDUR (MemRead=1, aluResult=0x100, rd=5), dm_ack after 3 cycles with dm_rdata=0xDEAD -> stall_M high for 2 cycles; then valid_W=1, rd_W=5, readData_W=0xDEAD, MemtoReg_W=1.
REQ-034 Scenario: STUR then LDUR back-to-back, ack same cycle as each request -> dm_req held high 2 consecutive cycles, first dm_we=1 with dm_wdata=writeData, stall_M never 1.
REQ-035 Scenario: CBZ (Branch=1, zero=1, PCBranch=0x40) -> PCSrc_M=1 for exactly 1 cycle with PCBranch_M=0x40; with zero=0, PCSrc_M stays 0.
REQ-036 Scenario: reset asserted in the 2nd ACCESS cycle -> dm_req falls without a clock edge, and valid_W stays 0 after release.
REQ-037 Scenario (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): LDUR, never ack -> abort after 4 stalled cycles, valid_W=1, RegWrite_W=0, dm_timeout=1 and sticky.
